tree_accumulator: RTL and testbench
===================================

# tree_accumulator

Downstream consumer of the pipelined adder tree in the GEMM datapath. It takes the tree's per-cycle reduced sum and carries the valid/last tags through a delay line that matches the tree latency. It accumulates consecutive valid sums into one dot-product result per `last`-terminated group and buffers finished results behind a ready/valid output. The tree itself cannot stall, so the block exposes `in_ready` credit gating to the tag source.

## Interface
- `DATA_WIDTH`, 32: width of the tree sum input.
- `LAYER`, 3: tree depth. Equals the tree latency in cycles.
- `ACC_WIDTH`, 32: accumulator and result width. Must be ≥ `DATA_WIDTH`.
- `OUT_DEPTH`, 2: result FIFO entries, ≥ 1.

Ports:
- `clk`  in  1  clock; everything on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tag_valid`  in  1  a beat is being presented to the tree's `data_in` this cycle.
- `tag_last`  in  1  the beat closes a dot-product group.
- `in_ready`  out  1  a beat presented this cycle is accepted.
- `sum_in`  in  `DATA_WIDTH`  tree `data_out`, two's complement.
- `out_data`  out  `ACC_WIDTH`  head-of-FIFO result.
- `out_valid`  out  1  `out_data` holds a result.
- `out_ready`  in  1  consumer takes the result.

## Operation
- **Beat acceptance:** a beat is accepted when `tag_valid && in_ready`. If `tag_valid && !in_ready`, the beat is dropped. The source must re-present both the tree data and the tags.
- **Delay line:** `LAYER`-stage shift register holding {valid, last}. An accepted beat enters stage 0. Stage `LAYER-1` (the aligned tag) coincides with the matching `sum_in`.
- **Accumulator register:** `acc` plus a `first` flag. On an aligned valid beat:
  - `s = (first ? 0 : acc) + sext(sum_in)`, wrapped modulo 2^`ACC_WIDTH` (no saturation, no overflow flag).
  - If the aligned tag is `last`: push `s` into the FIFO, set `first=1`; `acc` is don't-care.
  - Otherwise: `acc<=s`, `first<=0`.
- **Aligned invalid cycles:** `acc` and `first` are unchanged, so groups may contain bubbles.
- **Credit:** `pending` = FIFO occupancy + number of `last` tags in the delay line.
  - `in_ready = (pending < OUT_DEPTH) || !tag_last`. Non-last beats are always accepted.
  - Pops in the current cycle are not credited until the next cycle.
  - The credit rule guarantees the FIFO never overflows, because the tree cannot be stalled.
- **FIFO:** `out_valid` = non-empty. Pop on `out_valid && out_ready`. Simultaneous push and pop is legal at any occupancy, including full (push is legal there because credit was reserved).
- **Reset:** at any time, clears the delay line, FIFO, and `pending`, and sets `first=1`.
  - Outputs after reset: `out_valid=0`, `out_data=0`, `in_ready=1`.
  - Partial groups are discarded, and tree-internal data is ignored because all tags are cleared.

## Timing
- Beat presented with `last` in cycle t:
  - The aligned `sum_in` arrives in cycle t+`LAYER`.
  - The result is written at the end of t+`LAYER`.
  - With an empty FIFO, `out_valid=1` from cycle t+`LAYER`+1.
- Throughput: one beat per cycle. Back-to-back single-beat groups reach one result per cycle when `OUT_DEPTH` ≥ `LAYER`+1 and `out_ready=1`.
- `in_ready` is combinational from `tag_last` and registered state only. It does not depend on `out_ready`.
- `out_data` is driven from FIFO storage with no combinational path from inputs.

## Structure
- Shared package `gemm_pkg`:
  - tag struct `{valid, last}`.
  - sign-extension function.
  - `clog2`-based width constant for the `pending` counter (range 0..`OUT_DEPTH`).
- Sub-module `result_fifo` (parameters `WIDTH`, `DEPTH`; ports `clk`/`rst`, push, pop, data, count). Instantiated once.
- Delay line, accumulator, and credit logic stay inside `tree_accumulator`.

## Test plan
Defaults throughout: `LAYER=3`, `DATA_WIDTH=ACC_WIDTH=32`, `OUT_DEPTH=2`.
1. Group of sums 5, -2, 7 (3 beats, last on the third, presented cycles 0-2) → `out_data=10`, `out_valid` rises in cycle 6.
2. Single-beat groups with sums 1, 2, 3, 4 and `out_ready=1` → outputs 1, 2, 3, 4 in order. `in_ready` drops on the third `last` and the stall is honoured with no loss.
3. `out_ready=0`, three single-beat groups → `in_ready=0` on the third `last`. Releasing `out_ready` → pops 2 results, the re-presented beat is accepted, and 3 results total arrive in order.
4. Group 0x7FFFFFFF + 1 → `out_data=0x80000000` (wrap, no flag).
5. Group with invalid bubbles between beats with sums 3 and 4 → result 7. `rst` asserted mid-group → `out_valid=0`, `in_ready=1`, and the next group result excludes pre-reset beats.

Source files
------------

// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared tag type and width helpers for the GEMM reduction datapath
package gemm_pkg;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  localparam int SEXT_MAX = 64;

  // Sign-extends the low 'width' bits of value to SEXT_MAX bits; callers truncate to their width.
  function automatic logic [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] value, input int width);
    logic signed [SEXT_MAX-1:0] v_shl;
    v_shl = value << (SEXT_MAX - width);
    return v_shl >>> (SEXT_MAX - width);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - circular result buffer with occupancy count; push and pop may coincide when full
module result_fifo
  import gemm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/tree_accumulator.sv
// rtl/tree_accumulator.sv - aligns tags with the adder-tree latency, accumulates last-terminated groups, credit-gated result FIFO
module tree_accumulator
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LAYER      = 3,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tag_valid,
  input  logic                  tag_last,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] sum_in,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PEND_W = count_width(OUT_DEPTH);
  localparam logic [PEND_W-1:0] CREDITS = PEND_W'(OUT_DEPTH);

  tag_t               r_tags [LAYER];
  tag_t               w_aligned;
  logic               r_first;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [PEND_W-1:0]  r_pending;
  logic [PEND_W-1:0]  w_fifo_count;
  logic               w_accept;
  logic               w_credit_take;
  logic               w_pop;
  logic               w_push;

  // r_pending counts FIFO entries plus last tags still in flight, so a credit is held from acceptance to pop.
  assign in_ready      = (r_pending < CREDITS) || !tag_last;
  assign w_accept      = tag_valid && in_ready;
  assign w_credit_take = w_accept && tag_last;
  assign w_pop         = out_valid && out_ready;
  assign w_aligned     = r_tags[LAYER-1];
  assign w_push        = w_aligned.valid && w_aligned.last;
  assign w_ext         = ACC_WIDTH'(sext(SEXT_MAX'(sum_in), DATA_WIDTH));
  assign w_sum         = (r_first ? '0 : r_acc) + w_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAYER; i++) r_tags[i] <= '0;
    end else begin
      r_tags[0] <= tag_t'{valid: w_accept, last: w_credit_take};
      for (int i = 1; i < LAYER; i++) r_tags[i] <= r_tags[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_first   <= 1'b1;
      r_pending <= '0;
    end else begin
      if (w_aligned.valid) begin
        if (w_aligned.last) begin
          r_first <= 1'b1;
        end else begin
          r_acc   <= w_sum;
          r_first <= 1'b0;
        end
      end
      r_pending <= r_pending + PEND_W'(w_credit_take) - PEND_W'(w_pop);
    end
  end

  result_fifo #(
    .WIDTH (ACC_WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_sum),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_count (w_fifo_count)
  );

  assign out_valid = (w_fifo_count != '0);

endmodule

// File: tb/tb_tree_accumulator.sv
// tb/tb_tree_accumulator.sv - directed scoreboard bench for tree_accumulator with a behavioural adder-tree delay
module tb_tree_accumulator;

  localparam int LAYER = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tag_valid = 1'b0;
  logic        tag_last = 1'b0;
  logic        in_ready;
  logic [31:0] sum_in;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  logic [31:0] tree_in = '0;
  logic [31:0] tree_pipe [LAYER];

  logic [31:0] exp_q [$];
  logic [31:0] exp_acc = '0;
  int          checks = 0;
  int          errors = 0;
  logic        r1, r2, r3;

  always #5 clk = ~clk;

  // Stand-in for the non-stallable adder tree: fixed LAYER-cycle latency.
  always @(posedge clk) begin
    tree_pipe[0] <= tree_in;
    for (int i = 1; i < LAYER; i++) tree_pipe[i] <= tree_pipe[i-1];
  end
  assign sum_in = tree_pipe[LAYER-1];

  tree_accumulator #(
    .DATA_WIDTH (32),
    .LAYER      (LAYER),
    .ACC_WIDTH  (32),
    .OUT_DEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tag_valid (tag_valid),
    .tag_last  (tag_last),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one beat starting just after a rising edge; re-presents until accepted.
  task automatic beat(input logic [31:0] s, input logic last, output logic first_rdy);
    int tries;
    tries     = 0;
    first_rdy = 1'b0;
    tag_valid = 1'b1;
    tag_last  = last;
    tree_in   = s;
    forever begin
      @(negedge clk);
      if (tries == 0) first_rdy = in_ready;
      if (in_ready) begin
        exp_acc = exp_acc + s;
        if (last) begin
          exp_q.push_back(exp_acc);
          exp_acc = '0;
        end
        @(posedge clk); #1;
        break;
      end
      tries++;
      if (tries > 60) begin
        checks++;
        errors++;
        $error("FAIL beat_timeout observed=stalled expected=accepted");
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    tag_valid = 1'b0;
    tag_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_result observed=%h expected=none", out_data);
      end
      if (exp_q.size() != 0) check("result", out_data, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tag_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tag_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    beat(32'd5, 1'b0, r1);
    beat(-32'sd2, 1'b0, r1);
    beat(32'd7, 1'b1, r1);
    for (int k = 3; k < 6; k++) begin
      @(negedge clk);
      check("t1_no_early_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check("t1_valid_cycle6", 32'(out_valid), 32'd1);
    check("t1_data", out_data, 32'd10);
    drain();

    beat(32'd1, 1'b1, r1);
    beat(32'd2, 1'b1, r2);
    beat(32'd3, 1'b1, r3);
    check("t2_ready_first", 32'(r1), 32'd1);
    check("t2_ready_second", 32'(r2), 32'd1);
    check("t2_ready_third_stalls", 32'(r3), 32'd0);
    beat(32'd4, 1'b1, r1);
    drain();

    out_ready = 1'b0;
    beat(32'd10, 1'b1, r1);
    beat(32'd20, 1'b1, r2);
    check("t3_ready_first", 32'(r1), 32'd1);
    check("t3_ready_second", 32'(r2), 32'd1);
    repeat (4) @(negedge clk);
    check("t3_fifo_holds", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    tag_last = 1'b1;
    #1;
    check("t3_no_credit_last", 32'(in_ready), 32'd0);
    tag_last = 1'b0;
    #1;
    check("t3_nonlast_always_ready", 32'(in_ready), 32'd1);
    fork
      beat(32'd30, 1'b1, r3);
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check("t3_ready_third_stalls", 32'(r3), 32'd0);
    drain();

    beat(32'h7FFF_FFFF, 1'b0, r1);
    beat(32'd1, 1'b1, r1);
    drain();

    beat(32'd3, 1'b0, r1);
    repeat (2) @(posedge clk);
    #1;
    beat(32'd4, 1'b1, r1);
    drain();

    out_ready = 1'b0;
    beat(32'd50, 1'b1, r1);
    beat(32'd100, 1'b0, r1);
    beat(32'd200, 1'b0, r1);
    repeat (3) @(negedge clk);
    check("t5_fifo_before_rst", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    exp_acc = '0;
    tag_last = 1'b1;
    #2;
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_out_data", out_data, 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd1);
    tag_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    beat(32'd9, 1'b1, r1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
